// File: rtl/nano_mem.sv
// nano_mem -- single-port word memory behind a small request FSM.
//
// Flow: IDLE accepts a request (ce) and latches we/address/dataW. The FSM
// then spends WAIT cycles in WAITING and one cycle in DONE. The access is
// performed on the clock edge that ends the DONE cycle. A read result
// therefore appears on dataR in the cycle after ready.
//
// Ports
//   ck       clock, rising edge
//   rst      asynchronous active-high reset
//   ce       request strobe (only looked at in IDLE)
//   we       1 = write, 0 = read (sampled with ce)
//   address  word address (sampled with ce)
//   dataW    write data (sampled with ce)
//   dataR    read data register; holds until the next completed read
//   ready    high for the single DONE cycle
//   busy     high whenever the FSM is not in IDLE
//   err      out-of-range flag, asserted together with ready
//
// Build option: define NANO_MEM_BOUND_CHECK_EN to enable bounds checking.
// In that build, addresses >= DEPTH leave memory untouched, read back as
// zero and raise err. Without it, err is tied 0 and the address wraps
// onto its low log2(DEPTH) bits.
module nano_mem #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] dataW,
  output logic [DW-1:0] dataR,
  output logic          ready,
  output logic          busy,
  output logic          err
);
  localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   dat_q;
  logic [IW-1:0]   idx;
  logic            oob;
  logic [DW-1:0]   mem [DEPTH];

  assign idx = addr_q[IW-1:0];

`ifdef NANO_MEM_BOUND_CHECK_EN
  // Any set bit above the index field means the address lies beyond DEPTH.
  assign oob = |(addr_q >> IW);
  assign err = ready & oob;
`else
  assign oob = 1'b0;
  assign err = 1'b0;
`endif

  // The high address bits only matter in the bounds-checked build.
  logic unused_addr;
  assign unused_addr = ^addr_q;

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ce) state_nxt = (WAIT > 0) ? WAITING : DONE;
      WAITING: if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      dat_q  <= '0;
      dataR  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (ce) begin
          we_q   <= we;
          addr_q <= address;
          dat_q  <= dataW;
          cnt    <= WAIT_C;
        end
        WAITING: cnt <= cnt - 4'd1;
        DONE:    if (!we_q) dataR <= oob ? '0 : mem[idx];
        default: ;
      endcase
    end
  end

  // No reset and no init on the array: contents are undefined until written.
  // Reset forces state to IDLE at once, so an aborted write never lands.
  always_ff @(posedge ck) begin
    if (state == DONE && we_q && !oob) mem[idx] <= dat_q;
  end
endmodule

// File: tb/tb_nano_mem.sv
// Bench for nano_mem. Two instances share one stimulus stream:
//   u0: defaults (DEPTH=256, WAIT=0)
//   u1: DEPTH=16, WAIT=3
// A per-instance transaction model predicts busy/ready/err/dataR.
// Directed scenarios pin literal values; a random phase follows.
module tb_nano_mem;
  localparam int NI = 2;

  logic        ck = 1'b0, rst = 1'b0, ce = 1'b0, we = 1'b0;
  logic [7:0]  address = '0;
  logic [15:0] dataW = '0;
  logic [15:0] dr [NI];
  logic        bz [NI], rd [NI], er [NI];

  always #5 ck = ~ck;

  nano_mem u0 (
    .ck(ck), .rst(rst), .ce(ce), .we(we), .address(address), .dataW(dataW),
    .dataR(dr[0]), .ready(rd[0]), .busy(bz[0]), .err(er[0]));

  nano_mem #(.DEPTH(16), .WAIT(3)) u1 (
    .ck(ck), .rst(rst), .ce(ce), .we(we), .address(address), .dataW(dataW),
    .dataR(dr[1]), .ready(rd[1]), .busy(bz[1]), .err(er[1]));

  function automatic int wt(int i);  return (i == 0) ? 0 : 3;    endfunction
  function automatic int dep(int i); return (i == 0) ? 256 : 16; endfunction

  int total = 0, bad = 0, cyc = 0;

  // Model state: one outstanding transaction per instance.
  // The transaction completes at the end of cycle dcyc.
  logic [15:0] mmem   [NI][256];
  bit          mknown [NI][256];
  logic [15:0] mdr    [NI];
  bit          mdr_ok [NI];
  bit          pend   [NI];
  int          dcyc   [NI];
  bit          mwe    [NI];
  int          maddr  [NI];
  logic [15:0] mdat   [NI];
  int          rdy_cyc  [NI];
  bit          err_seen [NI];

  task automatic chk(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s u%0d: got %h want %h (cyc %0d)", nm, i, act, exp, cyc);
    end
  endtask

  function automatic void complete(int i);
    bit oob;
    int ix;
    oob = 1'b0;
`ifdef NANO_MEM_BOUND_CHECK_EN
    oob = (maddr[i] >= dep(i));
`endif
    ix = maddr[i] % dep(i);
    if (oob) begin
      if (!mwe[i]) begin mdr[i] = '0; mdr_ok[i] = 1'b1; end
    end else if (mwe[i]) begin
      mmem[i][ix] = mdat[i];
      mknown[i][ix] = 1'b1;
    end else begin
      mdr[i] = mmem[i][ix];
      mdr_ok[i] = mknown[i][ix];
    end
  endfunction

  // Model: advance on each clock edge; abort everything on reset.
  initial forever begin
    @(posedge ck or posedge rst);
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        pend[i] = 1'b0; mdr[i] = '0; mdr_ok[i] = 1'b1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (pend[i]) begin
          if (cyc - 1 == dcyc[i]) begin complete(i); pend[i] = 1'b0; end
        end else if (ce) begin
          pend[i] = 1'b1; mwe[i] = we; maddr[i] = int'(address);
          mdat[i] = dataW; dcyc[i] = cyc + wt(i);
        end
      end
    end
  end

  // Compare: every falling edge, all outputs of both instances.
  initial forever begin
    bit e_rdy, e_err;
    @(negedge ck);
    for (int i = 0; i < NI; i++) begin
      e_rdy = pend[i] && (cyc == dcyc[i]);
      e_err = 1'b0;
`ifdef NANO_MEM_BOUND_CHECK_EN
      e_err = e_rdy && (maddr[i] >= dep(i));
`endif
      chk("busy", i, int'(bz[i]), int'(pend[i]));
      chk("ready", i, int'(rd[i]), int'(e_rdy));
      chk("err", i, int'(er[i]), int'(e_err));
      if (mdr_ok[i]) chk("dataR", i, int'(dr[i]), int'(mdr[i]));
      if (rd[i]) rdy_cyc[i] = cyc;
      if (er[i]) err_seen[i] = 1'b1;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend[0] || pend[1]) && n < 60) begin @(negedge ck); #1; n++; end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", n);
    end
  endtask

  // One request accepted by both instances; checks latency of each.
  task automatic issue(input bit w, input int a, input int d);
    int t;
    wait_idle();
    for (int i = 0; i < NI; i++) begin rdy_cyc[i] = -100; err_seen[i] = 1'b0; end
    we = w; address = 8'(a); dataW = 16'(d); ce = 1'b1; t = cyc;
    @(negedge ck); #1; ce = 1'b0;
    wait_idle();
    chk("latency", 0, rdy_cyc[0] - t, 1);
    chk("latency", 1, rdy_cyc[1] - t, 4);
  endtask

  initial begin
    #1000000;
    total++; bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int t;
    #1 rst = 1'b1;
    repeat (2) @(negedge ck);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", i, int'(bz[i]), 0);
      chk("rst_ready", i, int'(rd[i]), 0);
      chk("rst_err", i, int'(er[i]), 0);
      chk("rst_dataR", i, int'(dr[i]), 0);
    end

    // Request presented as reset drops: taken on the first live edge.
    rst = 1'b0;
    issue(1'b1, 9, 'h1234);
    issue(1'b0, 9, 0);
    chk("rd9", 0, int'(dr[0]), 'h1234);
    chk("rd9", 1, int'(dr[1]), 'h1234);

    // Read on u1 with ce activity while busy: u1 ignores it, u0 takes one write.
    wait_idle();
    rdy_cyc[1] = -100;
    we = 1'b0; address = 8'd9; ce = 1'b1; t = cyc;
    for (int k = 1; k <= 5; k++) begin
      @(negedge ck); #1;
      if (k <= 3) begin we = 1'b1; address = 8'd9; dataW = 16'hDEAD; ce = 1'b1; end
      else ce = 1'b0;
      chk("w3_busy", 1, int'(bz[1]), (k <= 4) ? 1 : 0);
    end
    chk("w3_ready_at", 1, rdy_cyc[1] - t, 4);
    chk("w3_rd", 1, int'(dr[1]), 'h1234);
    issue(1'b0, 9, 0);
    chk("ign_rd9", 0, int'(dr[0]), 'hDEAD);
    chk("ign_rd9", 1, int'(dr[1]), 'h1234);

    // Writes leave dataR alone.
    issue(1'b1, 1, 'h4111);
    issue(1'b0, 1, 0);
    issue(1'b1, 1, 0);
    chk("hold", 0, int'(dr[0]), 'h4111);
    chk("hold", 1, int'(dr[1]), 'h4111);
    issue(1'b0, 1, 0);
    chk("rd1", 0, int'(dr[0]), 0);
    chk("rd1", 1, int'(dr[1]), 0);

    // Reset during u1's WAITING phase drops its pending write.
    issue(1'b1, 5, 'hBEEF);
    we = 1'b1; address = 8'd5; dataW = 16'hFFFF; ce = 1'b1;
    @(negedge ck); #1; ce = 1'b0;
    @(negedge ck); #1;
    chk("pre_rst_busy", 1, int'(bz[1]), 1);
    rst = 1'b1; #1;
    for (int i = 0; i < NI; i++) begin
      chk("abort_busy", i, int'(bz[i]), 0);
      chk("abort_ready", i, int'(rd[i]), 0);
      chk("abort_err", i, int'(er[i]), 0);
      chk("abort_dataR", i, int'(dr[i]), 0);
    end
    @(negedge ck); #1; rst = 1'b0;
    issue(1'b0, 5, 0);
    chk("abort_rd5", 0, int'(dr[0]), 'hFFFF);
    chk("abort_rd5", 1, int'(dr[1]), 'hBEEF);

`ifdef NANO_MEM_BOUND_CHECK_EN
    issue(1'b1, 3, 'h5555);
    issue(1'b1, 'h13, 'h00AA);
    chk("oob_wr_err", 1, int'(err_seen[1]), 1);
    chk("oob_wr_err", 0, int'(err_seen[0]), 0);
    issue(1'b0, 3, 0);
    chk("oob_rd3", 1, int'(dr[1]), 'h5555);
    issue(1'b0, 'h20, 0);
    chk("oob_rd20", 1, int'(dr[1]), 0);
    chk("oob_rd_err", 1, int'(err_seen[1]), 1);
`else
    issue(1'b1, 'h13, 'h00AA);
    issue(1'b0, 3, 0);
    chk("alias_rd3", 1, int'(dr[1]), 'h00AA);
    chk("alias_err", 1, int'(err_seen[1]), 0);
`endif

    // Random traffic, including occasional mid-access resets.
    for (int k = 0; k < 800; k++) begin
      @(negedge ck); #1;
      ce      = 1'($urandom_range(0, 1));
      we      = ($urandom_range(0, 2) == 0);
      address = 8'($urandom_range(0, 40));
      dataW   = 16'($urandom);
      rst     = ($urandom_range(0, 150) == 0);
    end
    ce = 1'b0; rst = 1'b0;
    wait_idle();
    @(negedge ck); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nano_mem.md
NANO_MEM -- requirements
Module: nano_mem

Interface
REQ-001 Parameter DW, default 16, data word width in bits.
REQ-002 Parameter AW, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of words; power of two, 2 <= DEPTH <= 2**AW.
REQ-004 Parameter WAIT, default 0, extra wait cycles per access; range 0..15.
REQ-005 ck  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ce  input  1  access request, sampled only in IDLE.
REQ-008 we  input  1  1 = write, 0 = read; sampled with ce.
REQ-009 address  input  AW  word address; sampled with ce.
REQ-010 dataW  input  DW  write data; sampled with ce.
REQ-011 dataR  output  DW  read data register.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high while an access is in flight (state != IDLE).
REQ-014 err  output  1  out-of-range flag, pulses with ready (macro builds only; tied 0 otherwise).

Function
REQ-015 The FSM SHALL have states IDLE, WAITING and DONE.
REQ-016 In IDLE with ce=1, the block SHALL latch we, address and dataW, load wait counter with WAIT, and go to WAITING if WAIT>0, else to DONE.
REQ-017 In WAITING, the counter SHALL decrement each cycle; at 1 the next state is DONE.
REQ-018 In DONE, the block SHALL perform the latched access, assert ready for exactly that cycle, and return to IDLE.
REQ-019 Accept-to-ready latency SHALL be exactly WAIT+1 cycles; back-to-back accesses are accepted no sooner than the cycle after ready (throughput 1 per WAIT+2 cycles).
REQ-020 ce, we, address and dataW SHALL be ignored while busy=1; latched values never change mid-access.
REQ-021 Read: dataR SHALL load mem[index] on the DONE edge and hold until the next completed read; writes SHALL NOT change dataR.
REQ-022 Write: mem[index] SHALL be updated on the DONE edge only.
REQ-023 Without the macro, index SHALL be the low log2(DEPTH) bits of the latched address (aliasing).
REQ-024 busy SHALL be 1 from the edge after ce acceptance through the DONE cycle inclusive.
REQ-025 Memory contents SHALL be undefined after power-up; no initialisation logic.

Reset
REQ-026 On rst=1, immediately and regardless of clock: state IDLE, counter 0, ready 0, busy 0, err 0, dataR all zeros.
REQ-027 Reset mid-access SHALL abort it: a pending write is discarded and memory contents are otherwise unchanged.
REQ-028 The first request SHALL be accepted on the first rising edge with rst=0 and ce=1.

Configuration
REQ-029 Macro NANO_MEM_BOUND_CHECK_EN SHALL select bounds checking.
REQ-030 With NANO_MEM_BOUND_CHECK_EN defined, an access with latched address >= DEPTH SHALL not touch memory, SHALL set dataR to zero on a read, and SHALL assert err together with ready for one cycle; latency is unchanged.
REQ-031 Without NANO_MEM_BOUND_CHECK_EN, err SHALL be constant 0 and REQ-023 aliasing SHALL apply.

Verification
REQ-032 Defaults, WAIT=0: write 0x1234 to addr 9 -> ready 1 cycle after accept; read addr 9 -> ready next-but-one cycle, dataR=0x1234.
REQ-033 WAIT=3: read accepted at cycle N -> ready exactly at N+4, busy high N+1..N+4, ce pulses during busy ignored.
REQ-034 Write 0xBEEF to addr 5, then assert rst during WAITING of a write of 0xFFFF to addr 5 -> outputs zero at once; later read addr 5 returns 0xBEEF.
REQ-035 DEPTH=16, macro undefined: write 0x00AA to addr 0x13 -> read addr 0x03 returns 0x00AA.
REQ-036 DEPTH=16, NANO_MEM_BOUND_CHECK_EN defined: write to addr 0x13 -> err=1 with ready, addr 0x03 unchanged; read addr 0x20 -> dataR=0, err=1.
REQ-037 Read addr 1 returning 0x4111, then write 0x0000 to addr 1 -> dataR stays 0x4111 until next read.
